// File: rtl/tinker_pkg.sv
// rtl/tinker_pkg.sv - Tinker execute-sequencer opcodes, field positions, states and decode helpers.
package tinker_pkg;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_XOR    = 5'b00010;
    localparam logic [4:0] OP_NOT    = 5'b00011;
    localparam logic [4:0] OP_SHFTR  = 5'b00100;
    localparam logic [4:0] OP_SHFTL  = 5'b00110;
    localparam logic [4:0] OP_MOV_RR = 5'b10001;
    localparam logic [4:0] OP_MOV_L  = 5'b10010;
    localparam logic [4:0] OP_ADDF   = 5'b10100;
    localparam logic [4:0] OP_SUBF   = 5'b10101;
    localparam logic [4:0] OP_MULF   = 5'b10110;
    localparam logic [4:0] OP_DIVF   = 5'b10111;
    localparam logic [4:0] OP_ADD    = 5'b11000;
    localparam logic [4:0] OP_SUB    = 5'b11010;
    localparam logic [4:0] OP_MUL    = 5'b11100;
    localparam logic [4:0] OP_DIV    = 5'b11101;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int RT_MSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int LIT_MSB = 11;
    localparam int LIT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_FWAIT,
        ST_WB
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_FPU,
        CLS_ILLEGAL
    } op_class_e;

    function automatic logic is_fpu_op(input logic [4:0] opcode);
        return opcode inside {OP_ADDF, OP_SUBF, OP_MULF, OP_DIVF};
    endfunction

    function automatic logic is_legal_op(input logic [4:0] opcode);
        return is_fpu_op(opcode) ||
               (opcode inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHFTR, OP_SHFTL,
                               OP_MOV_RR, OP_MOV_L, OP_ADD, OP_SUB, OP_MUL, OP_DIV});
    endfunction

endpackage

// File: rtl/tinker_op_classify.sv
// rtl/tinker_op_classify.sv - Combinational opcode decode into ALU, FPU or illegal class.
module tinker_op_classify
    import tinker_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        if (is_fpu_op(opcode)) begin
            op_class = CLS_FPU;
        end else if (is_legal_op(opcode)) begin
            op_class = CLS_ALU;
        end
    end

endmodule

// File: rtl/tinker_exec_ctrl.sv
// rtl/tinker_exec_ctrl.sv - Single-issue execute sequencer: read, ALU/FPU dispatch, writeback.
module tinker_exec_ctrl
    import tinker_pkg::*;
#(
    parameter int FPU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rf_rs_addr,
    output logic [4:0]       rf_rt_addr,
    input  logic [63:0]      rf_rs_data,
    input  logic [63:0]      rf_rt_data,
    output logic [4:0]       alu_opcode,
    output logic [63:0]      alu_op_a,
    output logic [63:0]      alu_op_b,
    output logic [11:0]      alu_lit,
    input  logic [63:0]      alu_result,
    output logic             fpu_start,
    output logic [4:0]       fpu_opcode,
    output logic [63:0]      fpu_op_a,
    output logic [63:0]      fpu_op_b,
    input  logic             fpu_done,
    input  logic [63:0]      fpu_result,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [63:0]      rf_wdata,
    output logic             illegal_op,
    output logic             fpu_timeout,
    output logic [CNT_W-1:0] retired
);

    localparam int TO_W = $clog2(FPU_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [4:0]       rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
    logic [4:0]       alu_opcode_q, alu_opcode_d;
    logic [63:0]      alu_op_a_q, alu_op_a_d, alu_op_b_q, alu_op_b_d;
    logic [11:0]      alu_lit_q, alu_lit_d;
    logic             fpu_start_q, fpu_start_d;
    logic [4:0]       fpu_opcode_q, fpu_opcode_d;
    logic [63:0]      fpu_op_a_q, fpu_op_a_d, fpu_op_b_q, fpu_op_b_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [63:0]      rf_wdata_q, rf_wdata_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [TO_W-1:0]  to_cnt_inc;
    op_class_e        op_class;

    tinker_op_classify u_classify (
        .opcode   (ir_q[OPC_MSB:OPC_LSB]),
        .op_class (op_class)
    );

    assign to_cnt_inc = to_cnt_q + TO_W'(1);

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        rs_addr_d    = rs_addr_q;
        rt_addr_d    = rt_addr_q;
        alu_opcode_d = alu_opcode_q;
        alu_op_a_d   = alu_op_a_q;
        alu_op_b_d   = alu_op_b_q;
        alu_lit_d    = alu_lit_q;
        fpu_start_d  = 1'b0;
        fpu_opcode_d = fpu_opcode_q;
        fpu_op_a_d   = fpu_op_a_q;
        fpu_op_b_d   = fpu_op_b_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        illegal_d    = 1'b0;
        timeout_d    = 1'b0;
        retired_d    = retired_q;
        to_cnt_d     = to_cnt_q;

        // Registered outputs are loaded on the transition into the state that presents them.
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    ir_d      = instr;
                    rs_addr_d = instr[RS_MSB:RS_LSB];
                    rt_addr_d = instr[RT_MSB:RT_LSB];
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                case (op_class)
                    CLS_ALU: begin
                        alu_opcode_d = ir_q[OPC_MSB:OPC_LSB];
                        alu_op_a_d   = rf_rs_data;
                        alu_op_b_d   = rf_rt_data;
                        alu_lit_d    = ir_q[LIT_MSB:LIT_LSB];
                        state_d      = ST_EXEC;
                    end
                    CLS_FPU: begin
                        fpu_opcode_d = ir_q[OPC_MSB:OPC_LSB];
                        fpu_op_a_d   = rf_rs_data;
                        fpu_op_b_d   = rf_rt_data;
                        fpu_start_d  = 1'b1;
                        state_d      = ST_EXEC;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                endcase
            end
            ST_EXEC: begin
                if (op_class == CLS_ALU) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = ir_q[RD_MSB:RD_LSB];
                    rf_wdata_d = alu_result;
                    state_d    = ST_WB;
                end else begin
                    to_cnt_d = '0;
                    state_d  = ST_FWAIT;
                end
            end
            ST_FWAIT: begin
                to_cnt_d = to_cnt_inc;
                // A result arriving on the last allowed cycle still beats the timeout.
                if (fpu_done) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = ir_q[RD_MSB:RD_LSB];
                    rf_wdata_d = fpu_result;
                    state_d    = ST_WB;
                end else if (to_cnt_inc >= TO_W'(FPU_TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WB: begin
                retired_d = retired_q + CNT_W'(1);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ir_q         <= '0;
            rs_addr_q    <= '0;
            rt_addr_q    <= '0;
            alu_opcode_q <= '0;
            alu_op_a_q   <= '0;
            alu_op_b_q   <= '0;
            alu_lit_q    <= '0;
            fpu_start_q  <= 1'b0;
            fpu_opcode_q <= '0;
            fpu_op_a_q   <= '0;
            fpu_op_b_q   <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            retired_q    <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            rs_addr_q    <= rs_addr_d;
            rt_addr_q    <= rt_addr_d;
            alu_opcode_q <= alu_opcode_d;
            alu_op_a_q   <= alu_op_a_d;
            alu_op_b_q   <= alu_op_b_d;
            alu_lit_q    <= alu_lit_d;
            fpu_start_q  <= fpu_start_d;
            fpu_opcode_q <= fpu_opcode_d;
            fpu_op_a_q   <= fpu_op_a_d;
            fpu_op_b_q   <= fpu_op_b_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            retired_q    <= retired_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign rf_rs_addr  = rs_addr_q;
    assign rf_rt_addr  = rt_addr_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_op_a    = alu_op_a_q;
    assign alu_op_b    = alu_op_b_q;
    assign alu_lit     = alu_lit_q;
    assign fpu_start   = fpu_start_q;
    assign fpu_opcode  = fpu_opcode_q;
    assign fpu_op_a    = fpu_op_a_q;
    assign fpu_op_b    = fpu_op_b_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign illegal_op  = illegal_q;
    assign fpu_timeout = timeout_q;
    assign retired     = retired_q;

endmodule
